// File: rtl/cic_decim_comb3_if.sv
// Sample/result bundle for cic_decim_comb3: integrator samples and ratio in, comb results out.
interface cic_decim_comb3_if #(
  parameter int DW    = 32,
  parameter int RW    = 8,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [DW-1:0]    data_in;
  logic [RW-1:0]    dec_ratio;
  logic             out_valid;
  logic [DW-1:0]    data_full;
  logic [OUT_W-1:0] data_out;

  modport master (
    output in_valid, data_in, dec_ratio,
    input  out_valid, data_full, data_out
  );

  modport slave (
    input  in_valid, data_in, dec_ratio,
    output out_valid, data_full, data_out
  );
endinterface

// File: rtl/cic_decim_comb3.sv
// CIC decimator plus three registered comb stages (differential delay 1).
// Define CIC_ROUND_EN for round-half-up scaling with positive clamp; default truncates.
module cic_decim_comb3 #(
  parameter int DW    = 32,
  parameter int RW    = 8,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16
) (
  input logic               clk,
  input logic               rst,
  cic_decim_comb3_if.slave  bus
);

  logic [RW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    r_eff_q, r_eff_d;
  logic [RW-1:0]    r_in;
  logic [DW-1:0]    dec_q, dec_d;
  // s_q[k] is the input strobe of comb stage k+1; s_q[3] feeds the output stage
  logic [3:0]       s_q, s_d;
  logic [DW-1:0]    y_q [3];
  logic [DW-1:0]    y_d [3];
  logic [DW-1:0]    xprev_q [3];
  logic [DW-1:0]    xprev_d [3];
  logic [DW-1:0]    x_in [3];
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    data_full_q, data_full_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;

`ifdef CIC_ROUND_EN
  function automatic logic [OUT_W-1:0] scale(input logic [DW-1:0] y);
    logic [DW:0]        rnd;
    logic signed [DW:0] sum;
    logic signed [DW:0] sh;
    logic signed [DW:0] max_v;
    rnd   = (DW+1)'(1) << (SHIFT - 1);
    sum   = $signed({y[DW-1], y} + rnd);
    sh    = sum >>> SHIFT;
    max_v = $signed((DW+1)'((64'd1 << (OUT_W - 1)) - 64'd1));
    if (sh > max_v) begin
      return max_v[OUT_W-1:0];
    end
    return sh[OUT_W-1:0];
  endfunction
`else
  function automatic logic [OUT_W-1:0] scale(input logic [DW-1:0] y);
    return OUT_W'($signed(y) >>> SHIFT);
  endfunction
`endif

  assign r_in = (bus.dec_ratio == '0) ? RW'(1) : bus.dec_ratio;

  always_comb begin
    cnt_d   = cnt_q;
    r_eff_d = r_eff_q;
    dec_d   = dec_q;
    s_d     = {s_q[2:0], 1'b0};
    if (bus.in_valid) begin
      if (cnt_q == r_eff_q - RW'(1)) begin
        cnt_d   = '0;
        dec_d   = bus.data_in;
        s_d[0]  = 1'b1;
        // ratio is only re-sampled here so a frame never changes length mid-way
        r_eff_d = r_in;
      end else begin
        cnt_d = cnt_q + RW'(1);
      end
    end
  end

  always_comb begin
    x_in[0] = dec_q;
    x_in[1] = y_q[0];
    x_in[2] = y_q[1];
    for (int unsigned k = 0; k < 3; k++) begin
      y_d[k]     = y_q[k];
      xprev_d[k] = xprev_q[k];
      if (s_q[k]) begin
        y_d[k]     = x_in[k] - xprev_q[k];
        xprev_d[k] = x_in[k];
      end
    end
  end

  always_comb begin
    out_valid_d = s_q[3];
    data_full_d = data_full_q;
    data_out_d  = data_out_q;
    if (s_q[3]) begin
      data_full_d = y_q[2];
      data_out_d  = scale(y_q[2]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      r_eff_q     <= r_in;
      dec_q       <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      data_full_q <= '0;
      data_out_q  <= '0;
      for (int unsigned k = 0; k < 3; k++) begin
        y_q[k]     <= '0;
        xprev_q[k] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      r_eff_q     <= r_eff_d;
      dec_q       <= dec_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      data_full_q <= data_full_d;
      data_out_q  <= data_out_d;
      for (int unsigned k = 0; k < 3; k++) begin
        y_q[k]     <= y_d[k];
        xprev_q[k] <= xprev_d[k];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_full = data_full_q;
  assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_cic_decim_comb3.sv
// Directed bench for cic_decim_comb3: ramp, latency, gaps, wrap, scaling, ratio change, reset.
module tb_cic_decim_comb3;
  localparam int DW = 32, RW = 8, OUT_W = 16, SHIFT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cic_decim_comb3_if #(.DW(DW), .RW(RW), .OUT_W(OUT_W)) bus ();

  cic_decim_comb3 #(.DW(DW), .RW(RW), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] full;
    logic [15:0] out;
    int unsigned cyc;
  } obs_t;
  obs_t obs_q[$];

  always @(negedge clk)
    if (bus.out_valid === 1'b1) obs_q.push_back('{bus.data_full, bus.data_out, cyc});

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] full_at(input int unsigned i);
    return (i < obs_q.size()) ? obs_q[i].full : 'x;
  endfunction

  function automatic logic [31:0] out_at(input int unsigned i);
    return (i < obs_q.size()) ? {16'h0, obs_q[i].out} : 'x;
  endfunction

  function automatic logic [31:0] gap_at(input int unsigned i);
    return (i + 1 < obs_q.size()) ? 32'(obs_q[i+1].cyc - obs_q[i].cyc) : 'x;
  endfunction

  // inputs are applied, then held across the edge that samples them
  task automatic drive(input logic v, input logic [31:0] d);
    bus.in_valid = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive(1'b0, 32'h0);
  endtask

  task automatic do_reset(input logic [7:0] ratio);
    bus.dec_ratio = ratio;
    rst = 1'b1;
    drive(1'b0, 32'h0);
    rst = 1'b0;
    obs_q.delete();
  endtask

  initial begin
    int unsigned acc0;
    logic [31:0] exp_ramp [5];
    logic [31:0] exp_gap  [4];
    logic [31:0] sc_in    [3];
    logic [31:0] sc_exp   [3];

    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.dec_ratio = 8'd4;

    // reset state
    do_reset(8'd4);
    check_eq("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("rst_data_full", bus.data_full, 32'h0);
    check_eq("rst_data_out", {16'h0, bus.data_out}, 32'h0);

    // ramp, R=4: kept 3,7,11,... -> 3,-2,-1,0,0
    exp_ramp = '{32'h3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h0};
    do_reset(8'd4);
    for (int n = 0; n < 24; n++) drive(1'b1, 32'(n));
    idle(6);
    check_eq("ramp_count", 32'(obs_q.size()), 32'd6);
    for (int i = 0; i < 5; i++) check_eq($sformatf("ramp_full[%0d]", i), full_at(i), exp_ramp[i]);
    check_eq("ramp_gap0", gap_at(0), 32'd4);
    check_eq("ramp_gap3", gap_at(3), 32'd4);

    // latency, R=1 with constant 0x100
    do_reset(8'd1);
    drive(1'b1, 32'h100);
    acc0 = cyc;
    repeat (7) drive(1'b1, 32'h100);
    idle(6);
    check_eq("lat_count", 32'(obs_q.size()), 32'd8);
    check_eq("lat_cycle", (obs_q.size() > 0) ? 32'(obs_q[0].cyc) : 'x, 32'(acc0 + 4));
    check_eq("lat_full0", full_at(0), 32'h0000_0100);
    check_eq("lat_full1", full_at(1), 32'hFFFF_FE00);
    check_eq("lat_full2", full_at(2), 32'h0000_0100);
    check_eq("lat_full3", full_at(3), 32'h0);
    check_eq("lat_full7", full_at(7), 32'h0);

    // R=2 gapless and with in_valid toggling: kept 1,3,5,7 -> 1,0,-1,0
    exp_gap = '{32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0};
    do_reset(8'd2);
    for (int n = 0; n < 8; n++) drive(1'b1, 32'(n));
    idle(6);
    check_eq("r2_count", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("r2_full[%0d]", i), full_at(i), exp_gap[i]);
    check_eq("r2_gap", gap_at(0), 32'd2);

    do_reset(8'd2);
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 32'(n));
      drive(1'b0, 32'hDEAD_0000);
    end
    idle(6);
    check_eq("gaps_count", 32'(obs_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("gaps_full[%0d]", i), full_at(i), exp_gap[i]);
    check_eq("gaps_gap0", gap_at(0), 32'd4);
    check_eq("gaps_gap2", gap_at(2), 32'd4);

    // wrap across 0x80000000, R=4
    do_reset(8'd4);
    for (int n = 0; n < 32; n++) drive(1'b1, 32'h7FFF_FFF0 + 32'(n));
    idle(6);
    check_eq("wrap_count", 32'(obs_q.size()), 32'd8);
    check_eq("wrap_full0", full_at(0), 32'h7FFF_FFF3);
    check_eq("wrap_full1", full_at(1), 32'h0000_001E);
    check_eq("wrap_full2", full_at(2), 32'h7FFF_FFEF);
    for (int i = 3; i < 8; i++) check_eq($sformatf("wrap_full[%0d]", i), full_at(i), 32'h0);

    // scaling: single held sample at R=1 makes first data_full equal the input
    sc_in = '{32'h0001_8000, 32'h7FFF_8000, 32'hFFFF_8000};
`ifdef CIC_ROUND_EN
    sc_exp = '{32'h0002, 32'h7FFF, 32'h0000};
`else
    sc_exp = '{32'h0001, 32'h7FFF, 32'hFFFF};
`endif
    for (int i = 0; i < 3; i++) begin
      do_reset(8'd1);
      drive(1'b1, sc_in[i]);
      idle(6);
      check_eq($sformatf("scale_full[%0d]", i), full_at(0), sc_in[i]);
      check_eq($sformatf("scale_out[%0d]", i), out_at(0), sc_exp[i]);
    end

    // ratio 4->2 mid-frame: kept 3,5,7,9,11 -> 3,-4,1,0,0
    do_reset(8'd4);
    drive(1'b1, 32'd0);
    drive(1'b1, 32'd1);
    bus.dec_ratio = 8'd2;
    drive(1'b1, 32'd2);
    drive(1'b1, 32'd3);
    acc0 = cyc;
    for (int n = 4; n < 12; n++) drive(1'b1, 32'(n));
    idle(6);
    check_eq("ratio_count", 32'(obs_q.size()), 32'd5);
    check_eq("ratio_cycle", (obs_q.size() > 0) ? 32'(obs_q[0].cyc) : 'x, 32'(acc0 + 4));
    check_eq("ratio_full0", full_at(0), 32'h3);
    check_eq("ratio_full1", full_at(1), 32'hFFFF_FFFC);
    check_eq("ratio_full2", full_at(2), 32'h1);
    check_eq("ratio_full3", full_at(3), 32'h0);
    check_eq("ratio_gap0", gap_at(0), 32'd2);

    // reset with samples in flight; dec_ratio=0 behaves as R=1
    do_reset(8'd0);
    drive(1'b1, 32'h100);
    drive(1'b1, 32'h100);
    rst = 1'b1;
    drive(1'b0, 32'h0);
    rst = 1'b0;
    idle(8);
    check_eq("flush_count", 32'(obs_q.size()), 32'd0);
    check_eq("flush_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check_eq("flush_data_full", bus.data_full, 32'h0);
    check_eq("flush_data_out", {16'h0, bus.data_out}, 32'h0);

    // R=0 after reset: every sample kept
    drive(1'b1, 32'h40);
    idle(6);
    check_eq("r0_count", 32'(obs_q.size()), 32'd1);
    check_eq("r0_full", full_at(0), 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
